// File: rtl/demux1x2_reg.sv
// demux1x2_reg: registered 1-to-2 valid/ready demux, one output register per branch; optional DEMUX_XFER_CNT_EN adds per-branch load counters
module demux1x2_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SELECT,
  input  logic [WIDTH-1:0] DATAIN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] DATAOUT1,
  output logic             OUT1_VALID,
  input  logic             OUT1_READY,
  output logic [WIDTH-1:0] DATAOUT2,
  output logic             OUT2_VALID,
  input  logic             OUT2_READY
`ifdef DEMUX_XFER_CNT_EN
  ,
  output logic [7:0]       CNT1,
  output logic [7:0]       CNT2
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state1_q, state1_d, state2_q, state2_d;
  logic [WIDTH-1:0] data1_q, data1_d, data2_q, data2_d;
  logic load1, load2;
  // readiness depends only on the selected branch; each branch loads, drains or holds
  always_comb begin
    IN_READY = SELECT ? (state2_q == EMPTY || OUT2_READY) : (state1_q == EMPTY || OUT1_READY);
    load1    = IN_VALID && IN_READY && !SELECT;
    load2    = IN_VALID && IN_READY && SELECT;
    state1_d = load1 ? FULL : (state1_q == FULL && OUT1_READY) ? EMPTY : state1_q;
    state2_d = load2 ? FULL : (state2_q == FULL && OUT2_READY) ? EMPTY : state2_q;
    data1_d  = load1 ? DATAIN : data1_q;
    data2_d  = load2 ? DATAIN : data2_q;
  end
  // branch state and data registers; reset drops any held word
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state1_q <= EMPTY;
      state2_q <= EMPTY;
      data1_q  <= '0;
      data2_q  <= '0;
    end else begin
      state1_q <= state1_d;
      state2_q <= state2_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
    end
  end
  assign OUT1_VALID = (state1_q == FULL);
  assign OUT2_VALID = (state2_q == FULL);
  assign DATAOUT1   = data1_q;
  assign DATAOUT2   = data2_q;
`ifdef DEMUX_XFER_CNT_EN
  logic [7:0] cnt1_q, cnt2_q;
  // per-branch input transfer counters, wrapping at 255
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_q + 8'(load1);
      cnt2_q <= cnt2_q + 8'(load2);
    end
  end
  assign CNT1 = cnt1_q;
  assign CNT2 = cnt2_q;
`endif
endmodule
